// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, RX FSM state codes
// and bit-timing helpers used by the RX (and future TX) blocks.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_BRKWAIT = 3'd5;

    // Clocks per bit (integer division).
    function automatic int calc_cpb(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Mid-bit cycle index.
    function automatic int calc_mid(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with full/empty/level, WIDTH x DEPTH (DEPTH power of 2).
// Ports: clk, reset (sync, high), wr_en/wr_data, rd_en/rd_data, full, empty, level.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_rd, do_wr;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == (AW + 1)'(DEPTH));
    // Head is forced to zero while empty so stale storage never leaks out.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_rd    = rd_en && !empty;
        // A write into a full FIFO is only accepted alongside a pop.
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: 2-flop sync, 3-sample mid-bit vote, parity/framing/break flags,
// frame FIFO drained by uart_rx_valid/uart_rx_ready. Ports: clk, reset, uart_rxd,
// uart_rx_en, uart_rx_ready -> uart_rx_valid/data/perr/ferr/break/overrun/level.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           uart_rxd,
    input  logic                           uart_rx_en,
    input  logic                           uart_rx_ready,
    output logic                           uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0]        uart_rx_data,
    output logic                           uart_rx_perr,
    output logic                           uart_rx_ferr,
    output logic                           uart_rx_break,
    output logic                           uart_rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]    uart_rx_level
);

    localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
    localparam int MID = calc_mid(CPB);
    localparam int CW  = $clog2(CPB + 1);
    localparam int PB  = PAYLOAD_BITS;
    localparam int EW  = PB + 3;

    logic          sync1_q, sync1_d, rxd_s_q, rxd_s_d;
    logic          h1_q, h1_d, h2_q, h2_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [PB-1:0] data_q, data_d;
    logic          par_q, par_d, perr_q, perr_d;
    logic          ferr_q, ferr_d, stz_q, stz_d;

    logic          sample, at_mid, at_end;
    logic          ferr_n, stz_n, brk, push, pop, full, empty;
    logic [EW-1:0] entry, head;

    // h2/h1/rxd_s are consecutive samples; at cnt==MID they straddle the bit centre.
    assign sample = (h2_q & h1_q) | (h2_q & rxd_s_q) | (h1_q & rxd_s_q);
    assign at_mid = (cnt_q == CW'(MID));
    assign at_end = (cnt_q == CW'(CPB - 1));

    always_comb begin
        sync1_d    = uart_rxd;
        rxd_s_d    = sync1_q;
        h1_d       = rxd_s_q;
        h2_d       = h1_q;
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stz_d      = stz_q;
        ferr_n     = ferr_q | ~sample;
        stz_n      = stz_q & ~sample;
        brk        = 1'b0;
        push       = 1'b0;
        entry      = '0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s_q) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    par_d      = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stz_d      = 1'b1;
                end
            end
            ST_START: begin
                if (at_mid && sample) begin
                    state_d = ST_IDLE;
                end else if (at_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_mid) begin
                    data_d = {sample, data_q[PB-1:1]};
                end
                if (at_end) begin
                    if (bit_idx_q == 4'(PB - 1)) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) begin
                    par_d  = sample;
                    // Odd parity wants XOR==1, so invert for odd.
                    perr_d = (^data_q) ^ sample ^ (PARITY == PARITY_ODD);
                end
                if (at_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_mid) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        // Push at mid of the last stop bit so the next start edge is not missed.
                        brk     = (data_q == '0) && !par_q && stz_n;
                        push    = 1'b1;
                        entry   = {brk, ferr_n, perr_q, data_q};
                        state_d = brk ? ST_BRKWAIT : ST_IDLE;
                    end else begin
                        ferr_d = ferr_n;
                        stz_d  = stz_n;
                    end
                end
                if (at_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            ST_BRKWAIT: begin
                if (rxd_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!uart_rx_en) begin
            state_d = ST_IDLE;
            push    = 1'b0;
        end
        if (state_d != state_q || at_end || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxd_s_q    <= 1'b1;
            h1_q       <= 1'b1;
            h2_q       <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stz_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            rxd_s_q    <= rxd_s_d;
            h1_q       <= h1_d;
            h2_q       <= h2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stz_q      <= stz_d;
        end
    end

    assign pop             = uart_rx_valid && uart_rx_ready;
    assign uart_rx_valid   = !empty;
    assign uart_rx_overrun = push && full && !pop;
    assign uart_rx_break   = head[EW-1];
    assign uart_rx_ferr    = head[EW-2];
    assign uart_rx_perr    = head[EW-3];
    assign uart_rx_data    = head[PB-1:0];

    uart_rx_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push),
        .wr_data(entry),
        .rd_en  (pop),
        .rd_data(head),
        .full   (full),
        .empty  (empty),
        .level  (uart_rx_level)
    );

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed testbench for uart_rx_ext: 8N1 instance (dut) and 8E1 instance (dut_p),
// 50 MHz clock, 1 Mbit/s line (50 clocks per bit).
module tb_uart_rx_ext;

    localparam int CPB = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd_a = 1'b1, en_a = 1'b1, rdy_a = 1'b0;
    logic       valid_a, perr_a, ferr_a, brk_a, ovr_a;
    logic [7:0] data_a;
    logic [2:0] lvl_a;
    logic       rxd_b = 1'b1, en_b = 1'b1, rdy_b = 1'b0;
    logic       valid_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [7:0] data_b;
    logic [2:0] lvl_b;

    int n_checks = 0;
    int n_fail = 0;
    int ovr_cnt = 0;

    always #10 clk = ~clk;

    always @(negedge clk) if (ovr_a === 1'b1) ovr_cnt <= ovr_cnt + 1;

    uart_rx_ext #(
        .CLK_HZ(50000000), .BIT_RATE(1000000), .PAYLOAD_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .uart_rxd(rxd_a), .uart_rx_en(en_a),
        .uart_rx_ready(rdy_a), .uart_rx_valid(valid_a), .uart_rx_data(data_a),
        .uart_rx_perr(perr_a), .uart_rx_ferr(ferr_a), .uart_rx_break(brk_a),
        .uart_rx_overrun(ovr_a), .uart_rx_level(lvl_a)
    );

    uart_rx_ext #(
        .CLK_HZ(50000000), .BIT_RATE(1000000), .PAYLOAD_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_p (
        .clk(clk), .reset(reset), .uart_rxd(rxd_b), .uart_rx_en(en_b),
        .uart_rx_ready(rdy_b), .uart_rx_valid(valid_b), .uart_rx_data(data_b),
        .uart_rx_perr(perr_b), .uart_rx_ferr(ferr_b), .uart_rx_break(brk_b),
        .uart_rx_overrun(ovr_b), .uart_rx_level(lvl_b)
    );

    // Drive n bits of f (f[0] first) on line a (sel=0) or b; call at a negedge.
    task automatic tx(input bit sel, input logic [11:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rxd_b = f[i];
            else rxd_a = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (sel) rxd_b = 1'b1;
        else rxd_a = 1'b1;
    endtask

    task automatic pop_a();
        @(negedge clk) rdy_a = 1'b1;
        @(negedge clk) rdy_a = 1'b0;
    endtask

    task automatic pop_b();
        @(negedge clk) rdy_b = 1'b1;
        @(negedge clk) rdy_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_a); end
        n_checks++;
        if (lvl_a !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", lvl_a); end
        n_checks++;
        if ({data_a, perr_a, ferr_a, brk_a, ovr_a} !== 12'h000) begin
            n_fail++; $display("FAIL rst_outs: got %h want 000", {data_a, perr_a, ferr_a, brk_a, ovr_a});
        end
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int first = -1;
        int pulses = 0;
        logic [10:0] got = '1;
        rdy_a = 1'b1;
        @(negedge clk);
        fork
            tx(1'b0, {2'b11, 1'b1, 8'h5A, 1'b0}, 10);
            begin
                for (int n = 1; n <= 700; n++) begin
                    @(posedge clk);
                    #1;
                    if (valid_a === 1'b1) begin
                        pulses++;
                        if (first < 0) begin
                            first = n;
                            got = {data_a, perr_a, ferr_a, brk_a};
                        end
                    end
                end
            end
        join
        rdy_a = 1'b0;
        // 2 sync cycles, then (9*50+25)+2 after the edge reaches rxd_s.
        n_checks++;
        if (first !== 479) begin n_fail++; $display("FAIL basic_latency: got %0d want 479", first); end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
        n_checks++;
        if (got !== {8'h5A, 3'b000}) begin n_fail++; $display("FAIL basic_data: got %h want %h", got, {8'h5A, 3'b000}); end
    endtask

    task automatic test_parity();
        @(negedge clk);
        tx(1'b1, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({valid_b, data_b, perr_b, ferr_b, brk_b} !== {1'b1, 8'h07, 3'b100}) begin
            n_fail++; $display("FAIL par_bad: got %h want %h", {valid_b, data_b, perr_b, ferr_b, brk_b}, {1'b1, 8'h07, 3'b100});
        end
        pop_b();
        tx(1'b1, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({valid_b, data_b, perr_b, ferr_b, brk_b} !== {1'b1, 8'h07, 3'b000}) begin
            n_fail++; $display("FAIL par_good: got %h want %h", {valid_b, data_b, perr_b, ferr_b, brk_b}, {1'b1, 8'h07, 3'b000});
        end
        pop_b();
        n_checks++;
        if (lvl_b !== 3'd0) begin n_fail++; $display("FAIL par_drain: got %0d want 0", lvl_b); end
    endtask

    task automatic test_break();
        @(negedge clk);
        tx(1'b0, {2'b11, 1'b0, 8'h41, 1'b0}, 10);
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if ({lvl_a, data_a, perr_a, ferr_a, brk_a} !== {3'd1, 8'h41, 3'b010}) begin
            n_fail++; $display("FAIL ferr_frame: got %h want %h", {lvl_a, data_a, perr_a, ferr_a, brk_a}, {3'd1, 8'h41, 3'b010});
        end
        pop_a();
        rxd_a = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        n_checks++;
        if (lvl_a !== 3'd1) begin n_fail++; $display("FAIL brk_held_level: got %0d want 1", lvl_a); end
        rxd_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if ({lvl_a, data_a, perr_a, ferr_a, brk_a} !== {3'd1, 8'h00, 3'b011}) begin
            n_fail++; $display("FAIL brk_entry: got %h want %h", {lvl_a, data_a, perr_a, ferr_a, brk_a}, {3'd1, 8'h00, 3'b011});
        end
        pop_a();
        tx(1'b0, {2'b11, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({lvl_a, data_a, perr_a, ferr_a, brk_a} !== {3'd1, 8'h3C, 3'b000}) begin
            n_fail++; $display("FAIL brk_after: got %h want %h", {lvl_a, data_a, perr_a, ferr_a, brk_a}, {3'd1, 8'h3C, 3'b000});
        end
        pop_a();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rxd_a = 1'b0;
        repeat (10) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if ({valid_a, lvl_a} !== 4'd0) begin n_fail++; $display("FAIL glitch_level: got %h want 0", {valid_a, lvl_a}); end
        n_checks++;
        if (dut.state_q !== 3'd0) begin n_fail++; $display("FAIL glitch_idle: got %0d want 0", dut.state_q); end
    endtask

    task automatic test_overrun();
        int base;
        @(negedge clk);
        base = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] d;
            d = 8'(i);
            tx(1'b0, {2'b11, 1'b1, d, 1'b0}, 10);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (lvl_a !== 3'd4) begin n_fail++; $display("FAIL ovr_level: got %0d want 4", lvl_a); end
        n_checks++;
        if (ovr_cnt - base !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - base); end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if ({valid_a, data_a} !== {1'b1, 8'(i)}) begin
                n_fail++; $display("FAIL ovr_drain%0d: got %h want %h", i, {valid_a, data_a}, {1'b1, 8'(i)});
            end
            pop_a();
        end
        n_checks++;
        if ({valid_a, lvl_a} !== 4'd0) begin n_fail++; $display("FAIL ovr_empty: got %h want 0", {valid_a, lvl_a}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        tx(1'b0, {2'b11, 1'b1, 8'h11, 1'b0}, 10);
        tx(1'b0, {2'b11, 1'b1, 8'h22, 1'b0}, 10);
        repeat (5) @(negedge clk);
        n_checks++;
        if (lvl_a !== 3'd2) begin n_fail++; $display("FAIL rmid_queued: got %0d want 2", lvl_a); end
        tx(1'b0, {2'b11, 1'b1, 8'h33, 1'b0}, 4);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_checks++;
        if ({valid_a, lvl_a} !== 4'd0) begin n_fail++; $display("FAIL rmid_cleared: got %h want 0", {valid_a, lvl_a}); end
        repeat (2 * CPB) @(negedge clk);
        tx(1'b0, {2'b11, 1'b1, 8'hC3, 1'b0}, 10);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({lvl_a, data_a, perr_a, ferr_a, brk_a} !== {3'd1, 8'hC3, 3'b000}) begin
            n_fail++; $display("FAIL rmid_after: got %h want %h", {lvl_a, data_a, perr_a, ferr_a, brk_a}, {3'd1, 8'hC3, 3'b000});
        end
        pop_a();
    endtask

    task automatic test_en_drop();
        @(negedge clk);
        tx(1'b0, {2'b11, 1'b1, 8'h11, 1'b0}, 10);
        tx(1'b0, {2'b11, 1'b1, 8'h22, 1'b0}, 10);
        tx(1'b0, {2'b11, 1'b1, 8'h33, 1'b0}, 4);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        en_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if (lvl_a !== 3'd2) begin n_fail++; $display("FAIL en_kept: got %0d want 2", lvl_a); end
        n_checks++;
        if (data_a !== 8'h11) begin n_fail++; $display("FAIL en_head0: got %h want 11", data_a); end
        pop_a();
        n_checks++;
        if (data_a !== 8'h22) begin n_fail++; $display("FAIL en_head1: got %h want 22", data_a); end
        pop_a();
        n_checks++;
        if ({valid_a, lvl_a} !== 4'd0) begin n_fail++; $display("FAIL en_empty: got %h want 0", {valid_a, lvl_a}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_en_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
